axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, slave-side ID width.
REQ-004 SHALL have parameter AXI_USER_WIDTH, default 1, user width; user inputs are ignored and user outputs drive 0.
REQ-005 SHALL have parameter MEM_WORDS, default 1024, backing-store depth in 32-bit words; must be a power of 2.
REQ-006 SHALL have parameter BASE_ADDR, default 32'h0010_0000, first byte address decoded.
REQ-007 clk  in  1  single clock; all logic is rising-edge.
REQ-008 rst  in  1  reset; asynchronous assert, active-high.
REQ-009 aw_valid/aw_ready  in/out  1/1  write-address handshake; aw_id in ID, aw_addr in ADDR, aw_len in 8, aw_size in 3, aw_burst in 2.
REQ-010 w_valid/w_ready  in/out  1/1  write data; w_data in 32, w_strb in 4, w_last in 1.
REQ-011 b_valid/b_ready  out/in  1/1  write response; b_id out ID, b_resp out 2.
REQ-012 ar_valid/ar_ready  in/out  1/1  read address; ar_id, ar_addr, ar_len, ar_size, ar_burst, with the same widths as the AW channel.
REQ-013 r_valid/r_ready  out/in  1/1  read data; r_id out ID, r_data out 32, r_resp out 2, r_last out 1.

Function
REQ-014 The FSM SHALL have states IDLE, WR_DATA, WR_RESP, RD_DATA; exactly one transaction is in service at a time.
REQ-015 In IDLE, aw_ready and ar_ready SHALL be high except when both valids are high.
REQ-016 When both valids are high in IDLE, only one SHALL be accepted: the channel not served last, with write winning after reset.
REQ-017 AW accept SHALL latch id, addr, len and burst, then go to WR_DATA.
REQ-018 In WR_DATA, w_ready SHALL be high; each beat with w_valid SHALL write enabled bytes per w_strb, then advance the address.
REQ-019 WR_DATA SHALL exit to WR_RESP after the beat counted as len+1; w_last is not used for counting.
REQ-020 A w_last mismatch against the beat count SHALL set a sticky SLVERR flag for that transaction.
REQ-021 WR_RESP SHALL hold b_valid with b_id equal to the latched id until b_ready, then return to IDLE; b_resp SHALL be 2'b00, or 2'b10 on error.
REQ-022 AR accept SHALL go to RD_DATA; the first r_valid SHALL come on the cycle after the AR handshake (1-cycle registered memory read).
REQ-023 r_data, r_id, r_resp and r_last SHALL stay stable while r_valid && !r_ready; the next beat SHALL be presented on the cycle after each handshake, giving zero-bubble bursts.
REQ-024 r_last SHALL be high on beat len+1 only; after that handshake the FSM SHALL return to IDLE.
REQ-025 Address advance: INCR adds 4 per beat, FIXED keeps the address; the word index SHALL wrap modulo MEM_WORDS.
REQ-026 Each of the following SHALL make every beat of the transaction SLVERR (2'b10), suppress all writes, and return r_data 0: WRAP burst (2'b10), reserved burst (2'b11), aw_size/ar_size other than 3'd2, or a start address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS).
REQ-027 An unaligned start address SHALL be aligned down to the word; it is not an error.
REQ-028 Beat count SHALL be a 9-bit counter so that len=255 (256 beats) is fully served.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE.
REQ-030 On rst, aw_ready, ar_ready, w_ready, b_valid, r_valid and r_last SHALL be 0.
REQ-031 On rst, b_id, r_id, b_resp, r_resp and r_data SHALL be 0, and the arbitration pointer SHALL select write.
REQ-032 Reset mid-burst SHALL abandon the transaction with no response; memory contents SHALL be retained, already-written beats persist, and the memory is not reset.
REQ-033 After rst deasserts, aw_ready and ar_ready SHALL go high on the first clock edge.

Structure
REQ-034 Package axi_mem_slave_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY=2'b00, SLVERR=2'b10), and the FSM state enum.
REQ-035 Sub-module axi_mem_slave_ram SHALL implement a single-port MEM_WORDS x 32 RAM with 4 byte-enables and a registered read; it is the only storage.

Verification
REQ-036 Write burst: AW INCR addr 0x0010_0000 len=3, W 0x11111111..0x44444444 strb 4'hF -> four w handshakes, then one B OKAY with matching id; a read of the same burst returns the four words in order with r_last on beat 4.
REQ-037 Byte strobe: write 0xAABBCCDD strb 4'b0101 over 0x00000000 at 0x0010_0010 -> read returns 0x00BB00DD.
REQ-038 Back-pressure: read len=7 with r_ready toggling 1-0-1-0 -> each beat is held stable while stalled and all 8 beats are delivered with no duplicates.
REQ-039 Simultaneous aw_valid and ar_valid after reset -> write accepted first; after B, read accepted without re-arbitration stall.
REQ-040 Errors: WRAP burst or addr 0x0020_0000 -> SLVERR on every R beat or on B, memory unchanged; w_last asserted early on len=3 -> B SLVERR.
REQ-041 rst pulse during beat 2 of a len=3 write -> all outputs are 0 next cycle, beats 1-2 persist, and no B is issued.

Source files
------------

// File: rtl/axi_mem_slave_pkg.sv
// Shared encodings for the AXI memory slave: burst types, response codes,
// the transfer-size value the slave accepts, and the FSM state enum.
// A helper decides whether a burst/size pair is legal for this slave.
package axi_mem_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only full 32-bit beats are served.
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_DATA
  } state_e;

  // WRAP and the reserved encoding are rejected, as is any narrow/wide size.
  function automatic logic xfer_ok(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == SIZE_WORD);
  endfunction

endpackage

// File: rtl/axi_mem_slave_ram.sv
// Single-port WORDS x 32 RAM with per-byte write enables and a registered
// read port. rdata only changes on an enabled read, so it holds its value
// while the caller stalls. Contents are never reset.
//   clk   : clock
//   en    : access enable (read when !we, write when we)
//   we    : write select
//   be    : byte enables for writes
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module axi_mem_slave_ram #(
  parameter int WORDS = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave serving one burst at a time from an on-chip RAM.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   aw_* / w_* / b_*         : write address, write data, write response
//   ar_* / r_*               : read address, read data
//   *_user                   : inputs ignored, outputs tied to 0
// Reads use the RAM's registered output directly: the RAM is read on the
// AR handshake and on every non-final R handshake, so beats stream with no
// bubble and hold naturally while r_ready is low. Decode errors (bad burst,
// bad size, address outside the window) suppress writes and zero read data
// for the whole transaction.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,   // only 32 is supported
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MEM_WORDS      = 1024, // power of 2
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h0010_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  // write address
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]                  aw_len,
  input  logic [2:0]                  aw_size,
  input  logic [1:0]                  aw_burst,
  input  logic [AXI_USER_WIDTH-1:0]   aw_user,
  // write data
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  input  logic [AXI_USER_WIDTH-1:0]   w_user,
  // write response
  output logic                        b_valid,
  input  logic                        b_ready,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  output logic [1:0]                  b_resp,
  output logic [AXI_USER_WIDTH-1:0]   b_user,
  // read address
  input  logic                        ar_valid,
  output logic                        ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]                  ar_len,
  input  logic [2:0]                  ar_size,
  input  logic [1:0]                  ar_burst,
  input  logic [AXI_USER_WIDTH-1:0]   ar_user,
  // read data
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [AXI_ID_WIDTH-1:0]     r_id,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output logic [1:0]                  r_resp,
  output logic                        r_last,
  output logic [AXI_USER_WIDTH-1:0]   r_user
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + (AXI_ADDR_WIDTH+1)'(4 * MEM_WORDS);

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  // Low address bits drop out in the shift, which is the align-down.
  function automatic logic [IDX_W-1:0] idx_of(input logic [AXI_ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic unused_user;
  assign unused_user = ^{aw_user, w_user, ar_user};
  assign b_user = '0;
  assign r_user = '0;

  state_e                  state;
  logic                    prio_wr;  // write wins the next tie
  logic                    idle_q;   // gates readies; low during and just after reset
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [IDX_W-1:0]        idx_q;
  logic [7:0]              len_q;
  logic [1:0]              burst_q;
  logic                    err_q;    // decode error for the whole transaction
  logic                    werr_q;   // sticky w_last mismatch
  logic [8:0]              cnt_q;    // 9 bits so 256-beat bursts complete

  logic both, aw_hs, ar_hs, w_hs, r_hs;
  logic aw_err, ar_err, w_is_last, w_mism;
  logic [IDX_W-1:0] idx_next;

  assign both     = aw_valid && ar_valid;
  assign aw_ready = idle_q && (!both || prio_wr);
  assign ar_ready = idle_q && (!both || !prio_wr);
  assign aw_hs    = aw_valid && aw_ready;
  assign ar_hs    = ar_valid && ar_ready;
  assign w_hs     = w_valid && w_ready;
  assign r_hs     = r_valid && r_ready;

  assign aw_err    = !xfer_ok(aw_burst, aw_size) || !in_range(aw_addr);
  assign ar_err    = !xfer_ok(ar_burst, ar_size) || !in_range(ar_addr);
  assign idx_next  = (burst_q == BURST_FIXED) ? idx_q : idx_q + 1'b1;
  assign w_is_last = (cnt_q == {1'b0, len_q});
  assign w_mism    = (w_last != w_is_last);

  // RAM port steering: the states never need the port at the same time.
  logic             ram_en, ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_rdata;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = idx_q;
    case (state)
      IDLE: begin
        ram_addr = idx_of(ar_addr);
        ram_en   = ar_hs;
      end
      WR_DATA: begin
        ram_we = 1'b1;
        ram_en = w_hs && !err_q;
      end
      RD_DATA: begin
        // prefetch the following beat as the current one is accepted
        ram_addr = idx_next;
        ram_en   = r_hs && !r_last;
      end
      default: ;
    endcase
  end

  axi_mem_slave_ram #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (w_strb),
    .addr  (ram_addr),
    .wdata (w_data),
    .rdata (ram_rdata)
  );

  assign r_data = (r_valid && !err_q) ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      prio_wr <= 1'b1;
      idle_q  <= 1'b0;
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      werr_q  <= 1'b0;
      cnt_q   <= '0;
      w_ready <= 1'b0;
      b_valid <= 1'b0;
      b_id    <= '0;
      b_resp  <= RESP_OKAY;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          idle_q <= 1'b1;
          if (aw_hs) begin
            state   <= WR_DATA;
            idle_q  <= 1'b0;
            prio_wr <= 1'b0;
            id_q    <= aw_id;
            idx_q   <= idx_of(aw_addr);
            len_q   <= aw_len;
            burst_q <= aw_burst;
            err_q   <= aw_err;
            werr_q  <= 1'b0;
            cnt_q   <= '0;
            w_ready <= 1'b1;
          end else if (ar_hs) begin
            state   <= RD_DATA;
            idle_q  <= 1'b0;
            prio_wr <= 1'b1;
            id_q    <= ar_id;
            idx_q   <= idx_of(ar_addr);
            len_q   <= ar_len;
            burst_q <= ar_burst;
            err_q   <= ar_err;
            cnt_q   <= '0;
            r_valid <= 1'b1;
            r_last  <= (ar_len == 8'd0);
            r_id    <= ar_id;
            r_resp  <= ar_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            idx_q <= idx_next;
            cnt_q <= cnt_q + 9'd1;
            if (w_mism) werr_q <= 1'b1;
            // beat count, not w_last, ends the burst
            if (w_is_last) begin
              state   <= WR_RESP;
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_id    <= id_q;
              b_resp  <= (err_q || werr_q || w_mism) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        WR_RESP: begin
          if (b_ready) begin
            b_valid <= 1'b0;
            state   <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              state   <= IDLE;
              idle_q  <= 1'b1;
            end else begin
              idx_q  <= idx_next;
              cnt_q  <= cnt_q + 9'd1;
              r_last <= ((cnt_q + 9'd1) == {1'b0, len_q});
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus tasks push expected R beats
// and B responses computed from a word-array memory model; a monitor pops
// and compares on every handshake and checks that stalled beats hold.
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  localparam int WORDS = 1024;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [3:0] aw_id, ar_id, b_id, r_id, w_strb;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size;
  logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
  logic aw_user, w_user, ar_user, b_user, r_user;

  axi_mem_slave dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_user(aw_user),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .w_last(w_last), .w_user(w_user),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_user(ar_user),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last), .r_user(r_user)
  );

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  logic [31:0] model [WORDS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int n_cmp = 0, n_bad = 0;
  int rr_mode = 0, br_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within bound, required one", what);
  endtask

  // ready drivers for the response channels
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       r_ready = 1'b1;
      1:       r_ready = ~r_ready;
      default: r_ready = ($urandom_range(0, 2) != 0);
    endcase
    b_ready = (br_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
  end

  // monitor / scoreboard
  logic   stalled = 1'b0;
  r_exp_t snap;
  always @(negedge clk) begin
    r_exp_t e;
    b_exp_t eb;
    if (rst) stalled = 1'b0;
    else begin
      if (stalled) begin
        check("r_hold_valid", r_valid, 1'b1);
        check("r_hold_beat", {r_id, r_data, r_resp, r_last}, {snap.id, snap.data, snap.resp, snap.last});
      end
      if (r_valid && r_ready) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL r_unexpected: beat with data %0h, required none", r_data);
        end else begin
          e = rq.pop_front();
          check("r_beat", {r_id, r_data, r_resp, r_last}, {e.id, e.data, e.resp, e.last});
        end
      end
      stalled = r_valid && !r_ready;
      snap = '{r_id, r_data, r_resp, r_last};
      if (b_valid && b_ready) begin
        if (bq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected: resp %0h id %0h, required none", b_resp, b_id);
        end else begin
          eb = bq.pop_front();
          check("b_resp", {b_id, b_resp}, {eb.id, eb.resp});
        end
      end
    end
  end

  function automatic logic bad_req(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return (bu > 2'b01) || (sz != 3'd2) || (a < BASE) || (a >= BASE + 4 * WORDS);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & (WORDS - 1));
  endfunction

  task automatic idle_inputs();
    aw_valid = 0; w_valid = 0; ar_valid = 0; w_last = 0; w_strb = 0; w_data = 0;
    aw_user = 0; w_user = 0; ar_user = 0;
    aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_aw_ready", aw_ready, 0); check("rst_ar_ready", ar_ready, 0);
    check("rst_w_ready", w_ready, 0);   check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);   check("rst_r_last", r_last, 0);
    check("rst_b_id", b_id, 0);         check("rst_r_id", r_id, 0);
    check("rst_b_resp", b_resp, 0);     check("rst_r_resp", r_resp, 0);
    check("rst_r_data", r_data, 0);
  endtask

  task automatic rand_beats(input int n, input bit strb_rand);
    for (int i = 0; i < n; i++) begin
      wd[i] = $urandom;
      ws[i] = strb_rand ? 4'($urandom) : 4'hF;
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [1:0] bu, input logic [2:0] sz, input int nb);
    int ix;
    ix = widx(a);
    if (bad_req(a, sz, bu)) return;
    for (int i = 0; i < nb; i++) begin
      for (int b = 0; b < 4; b++) if (ws[i][b]) model[ix][8*b +: 8] = wd[i][8*b +: 8];
      if (bu == BURST_INCR) ix = (ix + 1) % WORDS;
    end
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [2:0] sz, input logic [3:0] id);
    logic err;
    int ix;
    err = bad_req(a, sz, bu);
    ix = widx(a);
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back(r_exp_t'{id, err ? 32'h0 : model[ix], err ? RESP_SLVERR : RESP_OKAY, i == int'(len)});
      if (bu == BURST_INCR) ix = (ix + 1) % WORDS;
    end
  endtask

  task automatic wait_aw();
    int t = 0;
    @(negedge clk);
    while (!aw_ready && t < 200) begin @(negedge clk); t++; end
    if (!aw_ready) fail_to("aw_handshake");
    @(posedge clk); #1;
    aw_valid = 0;
  endtask

  task automatic wait_ar();
    int t = 0;
    @(negedge clk);
    while (!ar_ready && t < 200) begin @(negedge clk); t++; end
    if (!ar_ready) fail_to("ar_handshake");
    @(posedge clk); #1;
    ar_valid = 0;
    @(negedge clk);
    check("r_first_latency", r_valid, 1'b1);
  endtask

  task automatic send_w(input int nb, input int last_at);
    int t;
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin w_valid = 0; @(posedge clk); #1; end
      w_valid = 1; w_data = wd[i]; w_strb = ws[i]; w_last = (i == last_at);
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 200) begin @(negedge clk); t++; end
      if (!w_ready) begin fail_to("w_handshake"); break; end
      @(posedge clk); #1;
    end
    w_valid = 0; w_last = 0;
  endtask

  task automatic wait_b();
    int t = 0;
    @(negedge clk);
    while (!(b_valid && b_ready) && t < 500) begin @(negedge clk); t++; end
    if (!(b_valid && b_ready)) fail_to("b_handshake");
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int t = 0;
    while (rq.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (rq.size() != 0) begin fail_to("r_drain"); rq.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [2:0] sz, input logic [3:0] id, input int early);
    int last_at;
    last_at = (early >= 0) ? early : int'(len);
    model_write(a, bu, sz, int'(len) + 1);
    bq.push_back(b_exp_t'{id, (bad_req(a, sz, bu) || last_at != int'(len)) ? RESP_SLVERR : RESP_OKAY});
    aw_id = id; aw_addr = a; aw_len = len; aw_size = sz; aw_burst = bu; aw_valid = 1;
    wait_aw();
    send_w(int'(len) + 1, last_at);
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                         input logic [2:0] sz, input logic [3:0] id);
    exp_read(a, len, bu, sz, id);
    ar_id = id; ar_addr = a; ar_len = len; ar_size = sz; ar_burst = bu; ar_valid = 1;
    wait_ar();
    wait_r();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1;
    @(negedge clk); check_reset_outputs();
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    r_ready = 1; b_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); check_reset_outputs();
    @(posedge clk); #1 rst = 0;
    @(negedge clk); check("ready_before_first_edge", {aw_ready, ar_ready}, 2'b00);
    @(negedge clk); check("ready_after_first_edge", {aw_ready, ar_ready}, 2'b11);
    @(posedge clk); #1;

    // whole memory through four 256-beat bursts
    for (int k = 0; k < 4; k++) begin
      rand_beats(256, 0);
      do_write(BASE + 32'(k * 1024), 8'd255, BURST_INCR, 3'd2, 4'(k), -1);
    end
    do_read(BASE + 32'h3F0, 8'd255, BURST_INCR, 3'd2, 4'd7);

    // four-beat INCR write and read-back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h1111_1111 * (i + 1); ws[i] = 4'hF; end
    do_write(BASE, 8'd3, BURST_INCR, 3'd2, 4'd5, -1);
    do_read(BASE, 8'd3, BURST_INCR, 3'd2, 4'd6);

    // byte strobes over a zeroed word, plus an unaligned read address
    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(BASE + 32'h10, 8'd0, BURST_INCR, 3'd2, 4'd1, -1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(BASE + 32'h10, 8'd0, BURST_INCR, 3'd2, 4'd2, -1);
    do_read(BASE + 32'h13, 8'd0, BURST_INCR, 3'd2, 4'd3);

    // back-pressure on an 8-beat read
    rr_mode = 1;
    do_read(BASE + 32'h200, 8'd7, BURST_INCR, 3'd2, 4'd3);
    rr_mode = 0;

    // error cases
    rand_beats(4, 0);
    do_write(BASE + 32'h40, 8'd3, BURST_WRAP, 3'd2, 4'd8, -1);
    do_read(BASE + 32'h40, 8'd3, BURST_INCR, 3'd2, 4'd8);
    do_read(BASE + 32'h40, 8'd3, BURST_WRAP, 3'd2, 4'd9);
    rand_beats(2, 0);
    do_write(32'h0020_0000, 8'd1, BURST_INCR, 3'd2, 4'd10, -1);
    do_read(32'h0020_0000, 8'd1, BURST_INCR, 3'd2, 4'd10);
    do_read(BASE, 8'd1, BURST_INCR, 3'd2, 4'd11);
    do_read(BASE + 32'h80, 8'd0, BURST_RSVD, 3'd2, 4'd12);
    do_write(BASE + 32'h80, 8'd0, BURST_INCR, 3'd1, 4'd12, -1);
    do_read(BASE + 32'h80, 8'd0, BURST_INCR, 3'd2, 4'd12);
    // early w_last; zero strobes keep memory contents unambiguous
    rand_beats(4, 0);
    for (int i = 0; i < 4; i++) ws[i] = 4'h0;
    do_write(BASE + 32'h80, 8'd3, BURST_INCR, 3'd2, 4'd9, 1);

    // randomized traffic
    br_mode = 1; rr_mode = 2;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [1:0]  bu;
      logic [2:0]  sz;
      a = BASE + 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 1) ? BASE - 4 : BASE + 4 * WORDS + 32'($urandom_range(0, 255));
      len = 8'($urandom_range(0, 15));
      bu  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 14) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        rand_beats(int'(len) + 1, 1);
        do_write(a, len, bu, sz, 4'($urandom), -1);
      end else begin
        do_read(a, len, bu, sz, 4'($urandom));
      end
    end
    br_mode = 0; rr_mode = 0;

    // simultaneous AW/AR after reset: write first, read right after B
    pulse_reset();
    rand_beats(2, 0);
    model_write(BASE + 32'h100, BURST_INCR, 3'd2, 2);
    bq.push_back(b_exp_t'{4'd4, RESP_OKAY});
    exp_read(BASE + 32'h100, 8'd1, BURST_INCR, 3'd2, 4'd6);
    aw_id = 4'd4; aw_addr = BASE + 32'h100; aw_len = 8'd1; aw_size = 3'd2; aw_burst = BURST_INCR;
    ar_id = 4'd6; ar_addr = BASE + 32'h100; ar_len = 8'd1; ar_size = 3'd2; ar_burst = BURST_INCR;
    aw_valid = 1; ar_valid = 1;
    @(negedge clk);
    check("arb_tie_aw_ready", aw_ready, 1'b1);
    check("arb_tie_ar_ready", ar_ready, 1'b0);
    @(posedge clk); #1 aw_valid = 0;
    send_w(2, 1);
    wait_b();
    @(negedge clk); check("arb_ar_after_b", ar_ready, 1'b1);
    @(posedge clk); #1 ar_valid = 0;
    @(negedge clk); check("arb_r_latency", r_valid, 1'b1);
    wait_r();

    // reset in the middle of a 4-beat write
    rand_beats(4, 0);
    model_write(BASE + 32'h300, BURST_INCR, 3'd2, 2);
    aw_id = 4'd2; aw_addr = BASE + 32'h300; aw_len = 8'd3; aw_size = 3'd2; aw_burst = BURST_INCR;
    aw_valid = 1;
    wait_aw();
    send_w(2, 3);
    w_valid = 1; w_data = wd[2]; w_strb = 4'hF; w_last = 0; rst = 1;
    @(negedge clk); check_reset_outputs();
    w_valid = 0;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    do_read(BASE + 32'h300, 8'd3, BURST_INCR, 3'd2, 4'd1);

    repeat (4) @(posedge clk);
    check("leftover_b", bq.size(), 0);
    check("leftover_r", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
